// File: rtl/pipe_ctrl_fsm.sv
// pipe_ctrl_fsm
//   Elastic pipeline controller for STAGES external datapath registers. It
//   keeps one valid bit per stage and produces the per-stage load enables.
//   It provides full-throughput valid/ready handshakes on the input side
//   and the output side. It also supports a drain (flush) mode, a discard
//   (clear) mode, and a registered occupancy count.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   valid       feeder presents data
//   ready       controller accepts data this cycle (combinational)
//   valid_out   result present at last stage
//   ready_out   consumer accepts result this cycle
//   flush       pulse: stop accepting and drain the pipeline
//   clear       pulse: discard all in-flight data
//   en          load enable for stage register i
//   occupancy   number of valid stages (registered)
//   busy        controller is not IDLE
//   flush_done  one-cycle pulse when a drain completes
module pipe_ctrl_fsm #(
  parameter int STAGES = 3,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  output logic              valid_out,
  input  logic              ready_out,
  input  logic              flush,
  input  logic              clear,
  output logic [STAGES-1:0] en,
  output logic [CNT_W-1:0]  occupancy,
  output logic              busy,
  output logic              flush_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic [STAGES-1:0] sv_q, sv_d;
  logic [STAGES-1:0] adv;
  logic [CNT_W-1:0]  occ_q;
  logic              fd_q;
  logic              acc;

  function automatic logic [CNT_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // A stage may advance when it is empty, or when its successor advances.
  // The chain runs from the output back to the input. This lets a full
  // pipeline accept and retire in the same cycle.
  always_comb begin : adv_chain
    logic a;
    a   = ~sv_q[STAGES-1] | ready_out;
    adv = '0;
    adv[STAGES-1] = a;
    for (int i = STAGES - 2; i >= 0; i--) begin
      a      = ~sv_q[i] | a;
      adv[i] = a;
    end
  end

  // A flush in the same cycle takes precedence over new input, so it also
  // blocks acceptance.
  assign ready = adv[0] & (state_q != DRAIN) & ~clear & ~flush;
  assign acc   = valid & ready;

  always_comb begin : stage_next
    en   = '0;
    sv_d = sv_q;
    if (clear) begin
      sv_d = '0;
    end else begin
      en[0] = adv[0] & acc;
      if (adv[0]) sv_d[0] = acc;
      for (int i = 1; i < STAGES; i++) begin
        en[i] = adv[i] & sv_q[i-1];
        if (adv[i]) sv_d[i] = sv_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sv_q    <= '0;
      occ_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      sv_q  <= sv_d;
      occ_q <= popcount(sv_d);
      fd_q  <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (flush)    fd_q    <= 1'b1;
            else if (acc) state_q <= RUN;
          end
          RUN: begin
            if (flush) begin
              // Nothing left to drain: finish immediately.
              if (sv_d == '0) begin
                state_q <= IDLE;
                fd_q    <= 1'b1;
              end else begin
                state_q <= DRAIN;
              end
            end else if (sv_d == '0) begin
              state_q <= IDLE;
            end
          end
          DRAIN: begin
            if (sv_d == '0) begin
              state_q <= IDLE;
              fd_q    <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign valid_out  = sv_q[STAGES-1];
  assign occupancy  = occ_q;
  assign busy       = (state_q != IDLE);
  assign flush_done = fd_q;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// tb_pipe_ctrl_fsm
//   Directed testbench for pipe_ctrl_fsm. It instantiates three controllers
//   with STAGES = 3, 1 and 5. All three share one set of inputs, and each
//   has its own outputs.
module tb_pipe_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic       valid;
  logic       ready_out;
  logic       flush;
  logic       clear;

  logic       rdy3, vo3, busy3, fd3;
  logic [2:0] en3;
  logic [1:0] occ3;

  logic       rdy1, vo1, busy1, fd1;
  logic [0:0] en1;
  logic [0:0] occ1;

  logic       rdy5, vo5, busy5, fd5;
  logic [4:0] en5;
  logic [2:0] occ5;

  int checks;
  int errors;

  pipe_ctrl_fsm #(.STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .valid(valid), .ready(rdy3), .valid_out(vo3),
    .ready_out(ready_out), .flush(flush), .clear(clear), .en(en3),
    .occupancy(occ3), .busy(busy3), .flush_done(fd3)
  );

  pipe_ctrl_fsm #(.STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .valid(valid), .ready(rdy1), .valid_out(vo1),
    .ready_out(ready_out), .flush(flush), .clear(clear), .en(en1),
    .occupancy(occ1), .busy(busy1), .flush_done(fd1)
  );

  pipe_ctrl_fsm #(.STAGES(5)) dut5 (
    .clk(clk), .reset(reset), .valid(valid), .ready(rdy5), .valid_out(vo5),
    .ready_out(ready_out), .flush(flush), .clear(clear), .en(en5),
    .occupancy(occ5), .busy(busy5), .flush_done(fd5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ro, input logic f, input logic c);
    valid     = v;
    ready_out = ro;
    flush     = f;
    clear     = c;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0; ready_out = 1'b0; flush = 1'b0; clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", rdy3); end
    checks++; if (vo3 !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b expected 0", vo3); end
    checks++; if (en3 !== 3'b000) begin errors++; $display("FAIL reset_en got %b expected 000", en3); end
    checks++; if (occ3 !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d expected 0", occ3); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy3); end
    checks++; if (fd3 !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b expected 0", fd3); end
    checks++; if (rdy1 !== 1'b1 || rdy5 !== 1'b1) begin errors++; $display("FAIL reset_ready_params got %b/%b expected 1/1", rdy1, rdy5); end
    tick();
  endtask

  task automatic test_stream();
    int occ_e [10];
    int en_e  [10];
    int vo_e  [10];
    int bz_e  [10];
    int xfers;
    occ_e = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0};
    en_e  = '{1, 3, 7, 7, 7, 6, 4, 0, 0, 0};
    vo_e  = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    bz_e  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    xfers = 0;
    for (int k = 0; k < 10; k++) begin
      drive(k < 5, 1'b1, 1'b0, 1'b0);
      checks++; if (occ3 !== 2'(occ_e[k])) begin errors++; $display("FAIL stream_occ c%0d got %0d expected %0d", k, occ3, occ_e[k]); end
      checks++; if (en3 !== 3'(en_e[k])) begin errors++; $display("FAIL stream_en c%0d got %b expected %0d", k, en3, en_e[k]); end
      checks++; if (vo3 !== 1'(vo_e[k])) begin errors++; $display("FAIL stream_valid_out c%0d got %b expected %0d", k, vo3, vo_e[k]); end
      checks++; if (busy3 !== 1'(bz_e[k])) begin errors++; $display("FAIL stream_busy c%0d got %b expected %0d", k, busy3, bz_e[k]); end
      checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d got %b expected 1", k, rdy3); end
      if (vo3 === 1'b1 && ready_out === 1'b1) xfers++;
      tick();
    end
    checks++; if (xfers != 5) begin errors++; $display("FAIL stream_transfers got %0d expected 5", xfers); end
  endtask

  task automatic test_backpressure();
    int en_e [3];
    en_e = '{1, 3, 7};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL bp_fill_ready c%0d got %b expected 1", k, rdy3); end
      checks++; if (en3 !== 3'(en_e[k])) begin errors++; $display("FAIL bp_fill_en c%0d got %b expected %0d", k, en3, en_e[k]); end
      tick();
    end
    for (int h = 0; h < 2; h++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b expected 0", rdy3); end
      checks++; if (en3 !== 3'b000) begin errors++; $display("FAIL bp_full_en got %b expected 000", en3); end
      checks++; if (occ3 !== 2'd3) begin errors++; $display("FAIL bp_full_occ got %0d expected 3", occ3); end
      checks++; if (vo3 !== 1'b1) begin errors++; $display("FAIL bp_full_valid_out got %b expected 1", vo3); end
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b expected 1", rdy3); end
    checks++; if (en3 !== 3'b111) begin errors++; $display("FAIL bp_release_en got %b expected 111", en3); end
    checks++; if (vo3 !== 1'b1) begin errors++; $display("FAIL bp_release_valid_out got %b expected 1", vo3); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (occ3 !== 2'd3) begin errors++; $display("FAIL bp_after_occ got %0d expected 3", occ3); end
    checks++; if (vo3 !== 1'b1) begin errors++; $display("FAIL bp_after_valid_out got %b expected 1", vo3); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (occ3 !== 2'd0) begin errors++; $display("FAIL bp_drained_occ got %0d expected 0", occ3); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL bp_drained_busy got %b expected 0", busy3); end
    tick();
  endtask

  task automatic test_bubble();
    int occ_e [10];
    int en_e  [10];
    int vo_e  [10];
    occ_e = '{0, 1, 1, 2, 1, 2, 1, 1, 0, 0};
    en_e  = '{1, 2, 5, 2, 5, 2, 4, 0, 0, 0};
    vo_e  = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0};
    for (int k = 0; k < 10; k++) begin
      drive((k < 6) && (k % 2 == 0), 1'b1, 1'b0, 1'b0);
      checks++; if (en3 !== 3'(en_e[k])) begin errors++; $display("FAIL bubble_en c%0d got %b expected %0d", k, en3, en_e[k]); end
      checks++; if (vo3 !== 1'(vo_e[k])) begin errors++; $display("FAIL bubble_valid_out c%0d got %b expected %0d", k, vo3, vo_e[k]); end
      checks++; if (occ3 !== 2'(occ_e[k])) begin errors++; $display("FAIL bubble_occ c%0d got %0d expected %0d", k, occ3, occ_e[k]); end
      tick();
    end
  endtask

  task automatic test_flush();
    int xfers;
    xfers = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    // Flush together with valid: the input must be refused.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL flush_pulse_ready got %b expected 0", rdy3); end
    checks++; if (en3 !== 3'b110) begin errors++; $display("FAIL flush_pulse_en got %b expected 110", en3); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL flush_drain_ready got %b expected 0", rdy3); end
    checks++; if (en3 !== 3'b000) begin errors++; $display("FAIL flush_drain_en got %b expected 000", en3); end
    checks++; if (occ3 !== 2'd2) begin errors++; $display("FAIL flush_drain_occ got %0d expected 2", occ3); end
    checks++; if (busy3 !== 1'b1 || fd3 !== 1'b0) begin errors++; $display("FAIL flush_drain_status got busy=%b fd=%b expected busy=1 fd=0", busy3, fd3); end
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL flush_xfer1_ready got %b expected 0", rdy3); end
    checks++; if (en3 !== 3'b100) begin errors++; $display("FAIL flush_xfer1_en got %b expected 100", en3); end
    if (vo3 === 1'b1) xfers++;
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (rdy3 !== 1'b0 || fd3 !== 1'b0) begin errors++; $display("FAIL flush_xfer2 got ready=%b fd=%b expected 0/0", rdy3, fd3); end
    if (vo3 === 1'b1) xfers++;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (xfers != 2) begin errors++; $display("FAIL flush_transfers got %0d expected 2", xfers); end
    checks++; if (fd3 !== 1'b1) begin errors++; $display("FAIL flush_done_pulse got %b expected 1", fd3); end
    checks++; if (busy3 !== 1'b0 || rdy3 !== 1'b1 || occ3 !== 2'd0) begin errors++; $display("FAIL flush_idle got busy=%b ready=%b occ=%0d expected 0/1/0", busy3, rdy3, occ3); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (fd3 !== 1'b0) begin errors++; $display("FAIL flush_done_width got %b expected 0", fd3); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fd3 !== 1'b1 || busy3 !== 1'b0) begin errors++; $display("FAIL flush_idle_pulse got fd=%b busy=%b expected 1/0", fd3, busy3); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fd3 !== 1'b0) begin errors++; $display("FAIL flush_idle_pulse_end got %b expected 0", fd3); end
    tick();
  endtask

  task automatic test_clear();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (rdy3 !== 1'b0 || en3 !== 3'b000) begin errors++; $display("FAIL clear_cycle got ready=%b en=%b expected 0/000", rdy3, en3); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (occ3 !== 2'd0 || vo3 !== 1'b0) begin errors++; $display("FAIL clear_empty got occ=%0d vo=%b expected 0/0", occ3, vo3); end
    checks++; if (busy3 !== 1'b0 || fd3 !== 1'b0 || rdy3 !== 1'b1) begin errors++; $display("FAIL clear_status got busy=%b fd=%b ready=%b expected 0/0/1", busy3, fd3, rdy3); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fd3 !== 1'b0) begin errors++; $display("FAIL clear_no_flush_done got %b expected 0", fd3); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (rdy3 !== 1'b1 || vo3 !== 1'b0 || en3 !== 3'b000) begin errors++; $display("FAIL rstmid_hs got ready=%b vo=%b en=%b expected 1/0/000", rdy3, vo3, en3); end
    checks++; if (occ3 !== 2'd0 || busy3 !== 1'b0 || fd3 !== 1'b0) begin errors++; $display("FAIL rstmid_status got occ=%0d busy=%b fd=%b expected 0/0/0", occ3, busy3, fd3); end
    checks++; if (vo1 !== 1'b0 || occ5 !== 3'd0) begin errors++; $display("FAIL rstmid_params got vo1=%b occ5=%0d expected 0/0", vo1, occ5); end
    tick();
  endtask

  task automatic test_params();
    int first1, first5, x1, x5, a1, a5, max1, max5;
    first1 = -1; first5 = -1;
    x1 = 0; x5 = 0; a1 = 0; a5 = 0; max1 = 0; max5 = 0;
    for (int k = 0; k < 14; k++) begin
      drive(k < 4, 1'b1, 1'b0, 1'b0);
      if (k < 4) begin
        checks++; if (en1 !== 1'b1) begin errors++; $display("FAIL param1_en c%0d got %b expected 1", k, en1); end
      end
      if (k == 0) begin
        checks++; if (en5 !== 5'b00001) begin errors++; $display("FAIL param5_en c0 got %b expected 00001", en5); end
      end
      if (valid === 1'b1 && rdy1 === 1'b1) a1++;
      if (valid === 1'b1 && rdy5 === 1'b1) a5++;
      if (vo1 === 1'b1) begin x1++; if (first1 < 0) first1 = k; end
      if (vo5 === 1'b1) begin x5++; if (first5 < 0) first5 = k; end
      if (int'(occ1) > max1) max1 = int'(occ1);
      if (int'(occ5) > max5) max5 = int'(occ5);
      tick();
    end
    checks++; if (first1 != 1) begin errors++; $display("FAIL param1_latency got %0d expected 1", first1); end
    checks++; if (first5 != 5) begin errors++; $display("FAIL param5_latency got %0d expected 5", first5); end
    checks++; if (a1 != 4 || x1 != 4) begin errors++; $display("FAIL param1_count got acc=%0d xfer=%0d expected 4/4", a1, x1); end
    checks++; if (a5 != 4 || x5 != 4) begin errors++; $display("FAIL param5_count got acc=%0d xfer=%0d expected 4/4", a5, x5); end
    checks++; if (max1 != 1) begin errors++; $display("FAIL param1_occ_max got %0d expected 1", max1); end
    checks++; if (max5 != 4) begin errors++; $display("FAIL param5_occ_max got %0d expected 4", max5); end
    checks++; if (busy1 !== 1'b0 || busy5 !== 1'b0 || fd1 !== 1'b0 || fd5 !== 1'b0) begin errors++; $display("FAIL param_end got busy=%b/%b fd=%b/%b expected all 0", busy1, busy5, fd1, fd5); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_clear();
    test_reset_mid();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
